// File: rtl/ro_meas_seq_ctrl_if.sv
// Result drain link between the measurement core and the PS-side DMA.
// Latency: data_out/data_en are registered one cycle after the pop decision.
// Backpressure: the DMA holds transfer_active low to stop pops; data_out holds its last value.
interface ro_meas_seq_ctrl_if;
    logic [31:0] data_out;
    logic        data_en;
    logic        transfer_en;
    logic        transfer_active;

    modport master (
        output data_out,
        output data_en,
        output transfer_en,
        input  transfer_active
    );

    modport slave (
        input  data_out,
        input  data_en,
        input  transfer_en,
        output transfer_active
    );
endinterface

// File: rtl/ro_meas_seq_ctrl.sv
// Ring-oscillator sweep sequencer: heat, gated edge counting, result write, cool-down.
// Latency: one result word per cycle in WRITE; drained words appear one cycle after the pop.
// Backpressure: a full result FIFO stalls the FSM in WRITE; DMA stalls via transfer_active.
module ro_meas_seq_ctrl #(
    parameter int NUM_RO     = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DECOUPLE,
    input  logic [31:0]       meas_cmd,
    input  logic [31:0]       meas_mode,
    input  logic [31:0]       meas_time,
    input  logic [31:0]       meas_readouts,
    input  logic [31:0]       meas_heatup,
    input  logic [31:0]       meas_cooldown,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [NUM_RO-1:0] ro_enable,
    output logic              meas_done,
    ro_meas_seq_ctrl_if.master dma
);

    localparam int CH_W = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CH_W-1:0]      CH_LAST  = CH_W'(NUM_RO - 1);
    localparam logic [AW:0]          FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_HEAT, S_MEAS, S_WRITE, S_COOL, S_DRAIN, S_DONE
    } state_t;

    state_t state, state_nxt, win_first;

    logic [CH_W-1:0]      ch, ch_nxt, widx, widx_nxt;
    logic [31:0]          sweep, sweep_nxt, timer;
    logic                 mode_q;
    logic [31:0]          time_q, reads_q, heat_q, cool_q;
    logic                 cmd0_q, start, abort, active;
    logic                 push, cnt_clr, adv, last_ch, last_sweep;
    logic [NUM_RO-1:0]    sync1, sync2, sync3, ro_rise, en_mask;
    logic [CNT_WIDTH-1:0] cnt [NUM_RO];
    logic [31:0]          word;

    logic [31:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [AW:0]          fcnt;
    logic                 fifo_full, fifo_empty, pop;
    logic [31:0]          dout_q;
    logic                 den_q;
    logic                 unused_bits;

    assign unused_bits = ^{meas_cmd[31:2], meas_mode[31:1]};

    // Start is a rising edge of cmd bit 0, suppressed by abort or decouple.
    assign start  = meas_cmd[0] & ~cmd0_q & ~meas_cmd[1] & ~DECOUPLE;
    assign abort  = meas_cmd[1] | DECOUPLE;
    assign active = (state != S_IDLE) && (state != S_DONE);

    assign win_first  = (heat_q == 32'd0) ? S_MEAS : S_HEAT;
    assign last_ch    = mode_q || (ch == CH_LAST);
    assign last_sweep = (sweep == reads_q - 32'd1);

    assign en_mask   = mode_q ? {NUM_RO{1'b1}} : (NUM_RO'(1) << ch);
    assign ro_enable = ((state == S_HEAT) || (state == S_MEAS)) ? en_mask : '0;
    assign meas_done = (state == S_DONE);

    // Sequential mode reports the active channel; parallel mode walks all channels.
    assign word = mode_q ? 32'(cnt[widx]) : 32'(cnt[ch]);

    assign fifo_full  = (fcnt == FULL_CNT);
    assign fifo_empty = (fcnt == '0);
    assign pop        = ~fifo_empty & dma.transfer_active & ~DECOUPLE;

    assign dma.transfer_en = ~fifo_empty & ~DECOUPLE;
    assign dma.data_en     = den_q & ~DECOUPLE;
    assign dma.data_out    = dout_q;

    // Next-state and sequencing decisions; abort/decouple override everything in a run.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        widx_nxt  = widx;
        sweep_nxt = sweep;
        push      = 1'b0;
        cnt_clr   = 1'b0;
        adv       = 1'b0;
        if (active && abort) begin
            state_nxt = S_IDLE;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_nxt = (meas_heatup == 32'd0) ? S_MEAS : S_HEAT;
                        ch_nxt    = '0;
                        widx_nxt  = '0;
                        sweep_nxt = '0;
                        cnt_clr   = 1'b1;
                    end
                end
                S_HEAT: begin
                    if (timer == heat_q - 32'd1) state_nxt = S_MEAS;
                end
                S_MEAS: begin
                    if (timer == time_q - 32'd1) begin
                        state_nxt = S_WRITE;
                        widx_nxt  = '0;
                    end
                end
                S_WRITE: begin
                    if (!fifo_full) begin
                        push = 1'b1;
                        if (!mode_q || (widx == CH_LAST)) begin
                            if (cool_q != 32'd0) state_nxt = S_COOL;
                            else                 adv       = 1'b1;
                        end else begin
                            widx_nxt = widx + CH_W'(1);
                        end
                    end
                end
                S_COOL: begin
                    if (timer == cool_q - 32'd1) adv = 1'b1;
                end
                S_DRAIN: begin
                    if (fifo_empty) state_nxt = S_DONE;
                end
                default: state_nxt = S_IDLE;
            endcase
            if (adv) begin
                if (!last_ch) begin
                    ch_nxt    = ch + CH_W'(1);
                    state_nxt = win_first;
                    cnt_clr   = 1'b1;
                end else if (!last_sweep) begin
                    ch_nxt    = '0;
                    sweep_nxt = sweep + 32'd1;
                    state_nxt = win_first;
                    cnt_clr   = 1'b1;
                end else begin
                    state_nxt = S_DRAIN;
                end
            end
        end
    end

    // FSM state, sequencing indices and the per-state cycle timer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= S_IDLE;
            ch     <= '0;
            widx   <= '0;
            sweep  <= '0;
            timer  <= '0;
            cmd0_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ch     <= ch_nxt;
            widx   <= widx_nxt;
            sweep  <= sweep_nxt;
            timer  <= (state_nxt != state) ? 32'd0 : timer + 32'd1;
            cmd0_q <= meas_cmd[0];
        end
    end

    // Control words are captured at start so PS writes mid-run have no effect.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mode_q  <= 1'b0;
            time_q  <= 32'd1;
            reads_q <= 32'd1;
            heat_q  <= '0;
            cool_q  <= '0;
        end else if ((state == S_IDLE || state == S_DONE) && start) begin
            mode_q  <= meas_mode[0];
            time_q  <= (meas_time == 32'd0) ? 32'd1 : meas_time;
            reads_q <= (meas_readouts == 32'd0) ? 32'd1 : meas_readouts;
            heat_q  <= meas_heatup;
            cool_q  <= meas_cooldown;
        end
    end

    // Two-flop synchroniser plus a third flop for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= ro_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign ro_rise = sync2 & ~sync3;

    // Saturating edge counters, live only in MEASURE for enabled channels.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_RO; i++) begin
            if (RESET || cnt_clr) begin
                cnt[i] <= '0;
            end else if ((state == S_MEAS) && en_mask[i] && ro_rise[i] && (cnt[i] != CNT_MAX)) begin
                cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    // Result storage; push is only raised when the FIFO has room.
    always_ff @(posedge CLK) begin
        if (push) mem[wptr] <= word;
    end

    // FIFO pointers and occupancy; decouple flushes the contents.
    always_ff @(posedge CLK) begin
        if (RESET || DECOUPLE) begin
            wptr <= '0;
            rptr <= '0;
            fcnt <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   fcnt <= fcnt + (AW+1)'(1);
                2'b01:   fcnt <= fcnt - (AW+1)'(1);
                default: fcnt <= fcnt;
            endcase
        end
    end

    // Registered drain output: word and strobe appear the cycle after the pop.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dout_q <= '0;
            den_q  <= 1'b0;
        end else begin
            den_q <= pop;
            if (pop) dout_q <= mem[rptr];
        end
    end

endmodule

// File: tb/tb_ro_meas_seq_ctrl.sv
// Scoreboard bench for the RO sweep sequencer (32-bit and 4-bit counter instances).
// Latency: words are checked at the negedge on which data_en is seen high.
// Backpressure: transfer_active is driven by the stimulus to exercise WRITE stalls.
module tb_ro_meas_seq_ctrl;
    localparam int NR = 4;

    logic          CLK = 1'b0;
    logic          RESET, DECOUPLE;
    logic [31:0]   meas_cmd, meas_mode, meas_time, meas_readouts, meas_heatup, meas_cooldown;
    logic [NR-1:0] ro_in, ro_enable, sat_ro_enable;
    logic          meas_done, sat_meas_done;

    ro_meas_seq_ctrl_if bus();
    ro_meas_seq_ctrl_if sat_bus();
    assign sat_bus.transfer_active = bus.transfer_active;

    always #5 CLK = ~CLK;

    ro_meas_seq_ctrl #(.NUM_RO(NR), .CNT_WIDTH(32), .FIFO_DEPTH(4)) u_dut (
        .CLK(CLK), .RESET(RESET), .DECOUPLE(DECOUPLE),
        .meas_cmd(meas_cmd), .meas_mode(meas_mode), .meas_time(meas_time),
        .meas_readouts(meas_readouts), .meas_heatup(meas_heatup), .meas_cooldown(meas_cooldown),
        .ro_in(ro_in), .ro_enable(ro_enable), .meas_done(meas_done), .dma(bus.master)
    );

    ro_meas_seq_ctrl #(.NUM_RO(NR), .CNT_WIDTH(4), .FIFO_DEPTH(4)) u_sat (
        .CLK(CLK), .RESET(RESET), .DECOUPLE(DECOUPLE),
        .meas_cmd(meas_cmd), .meas_mode(meas_mode), .meas_time(meas_time),
        .meas_readouts(meas_readouts), .meas_heatup(meas_heatup), .meas_cooldown(meas_cooldown),
        .ro_in(ro_in), .ro_enable(sat_ro_enable), .meas_done(sat_meas_done), .dma(sat_bus.master)
    );

    int n_chk = 0, n_err = 0;
    int exp_q[$], tol_q[$], sexp_q[$], stol_q[$];
    int n_words = 0, n_swords = 0;
    int per[NR], ph[NR];
    logic          seq_mon = 1'b0;
    logic [NR-1:0] prev_en = '0;
    logic [NR-1:0] en_seq[$];
    int onehot_viol = 0;
    int m_e, m_t, s_e, s_t;

    task automatic chk(input string tag, input longint obs, input longint exp, input int tol = 0);
        n_chk++;
        if (obs < exp - tol || obs > exp + tol) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input int v, input int t);
        exp_q.push_back(v);
        tol_q.push_back(t);
        if (v - t > 15) begin
            sexp_q.push_back(15);
            stol_q.push_back(0);
        end else begin
            sexp_q.push_back(v > 15 ? 15 : v);
            stol_q.push_back(t);
        end
    endtask

    task automatic setup(input int mode, input int tm, input int rd, input int ht, input int cl);
        meas_mode = 32'(mode); meas_time = 32'(tm); meas_readouts = 32'(rd);
        meas_heatup = 32'(ht); meas_cooldown = 32'(cl);
    endtask

    task automatic start_run();
        meas_cmd[0] = 1'b1;
        tick(1);
        meas_cmd[0] = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        for (int i = 0; i < max && !meas_done; i++) tick(1);
        chk(tag, meas_done, 1);
    endtask

    task automatic wait_en(input logic [NR-1:0] m, input int max, input string tag);
        for (int i = 0; i < max && ro_enable != m; i++) tick(1);
        chk(tag, ro_enable, m);
    endtask

    // Ring-oscillator model: square wave per channel, updated away from the clock edge.
    initial begin
        ro_in = '0;
        for (int k = 0; k < NR; k++) begin per[k] = 10; ph[k] = 0; end
        forever begin
            @(posedge CLK);
            #2;
            for (int k = 0; k < NR; k++) begin
                ph[k]    = (ph[k] + 1) % per[k];
                ro_in[k] = (ph[k] < per[k] / 2);
            end
        end
    end

    // Scoreboard pop for both instances, plus enable-pattern monitor for sequential mode.
    always @(negedge CLK) begin
        if (bus.data_en) begin
            n_words++;
            if (exp_q.size() == 0) chk("extra_word", 1, 0);
            else begin
                m_e = exp_q.pop_front(); m_t = tol_q.pop_front();
                chk("word", bus.data_out, m_e, m_t);
            end
        end
        if (sat_bus.data_en) begin
            n_swords++;
            if (sexp_q.size() == 0) chk("sat_extra_word", 1, 0);
            else begin
                s_e = sexp_q.pop_front(); s_t = stol_q.pop_front();
                chk("sat_word", sat_bus.data_out, s_e, s_t);
            end
        end
        if (seq_mon) begin
            if ((ro_enable & (ro_enable - 1'b1)) != '0) onehot_viol++;
            if (ro_enable != '0 && prev_en == '0) en_seq.push_back(ro_enable);
        end
        prev_en <= ro_enable;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, sw0;
        RESET = 1'b1; DECOUPLE = 1'b0; meas_cmd = '0; bus.transfer_active = 1'b1;
        setup(0, 100, 1, 5, 3);
        tick(3);
        RESET = 1'b0;
        tick(1);
        chk("rst_en", ro_enable, 0);
        chk("rst_ten", bus.transfer_en, 0);
        chk("rst_den", bus.data_en, 0);
        chk("rst_dout", bus.data_out, 0);
        chk("rst_done", meas_done, 0);

        // Reset held three cycles in the middle of MEASURE.
        start_run();
        wait_en(4'b0001, 20, "rst_heat_en");
        tick(20);
        RESET = 1'b1;
        tick(3);
        chk("rstmid_en", ro_enable, 0);
        chk("rstmid_ten", bus.transfer_en, 0);
        chk("rstmid_den", bus.data_en, 0);
        chk("rstmid_done", meas_done, 0);
        RESET = 1'b0;
        tick(1);

        // Sequential sweep, all taps at period 10.
        for (int k = 0; k < NR; k++) push_exp(10, 1);
        w0 = n_words; seq_mon = 1'b1;
        start_run();
        wait_done(3000, "seq_done");
        chk("seq_words", n_words - w0, 4);
        seq_mon = 1'b0;
        chk("seq_onehot", onehot_viol, 0);
        chk("seq_nen", en_seq.size(), 4);
        for (int k = 0; k < NR && k < en_seq.size(); k++) chk("seq_order", en_seq[k], 1 << k);
        tick(5);
        chk("seq_done_hold", meas_done, 1);

        // Parallel sweep, two readouts.
        per[0] = 4; per[1] = 6; per[2] = 8; per[3] = 10;
        setup(1, 120, 2, 5, 3);
        for (int r = 0; r < 2; r++) begin
            push_exp(30, 1); push_exp(20, 1); push_exp(15, 1); push_exp(12, 1);
        end
        w0 = n_words;
        start_run();
        chk("par_done_clr", meas_done, 0);
        tick(65);
        chk("par_en", ro_enable, 4'hF);
        wait_done(3000, "par_done");
        chk("par_words", n_words - w0, 8);

        // Backpressure: DMA idle until the FSM is stuck in WRITE with a full FIFO.
        bus.transfer_active = 1'b0;
        setup(1, 120, 3, 5, 3);
        for (int r = 0; r < 3; r++) begin
            push_exp(30, 1); push_exp(20, 1); push_exp(15, 1); push_exp(12, 1);
        end
        w0 = n_words;
        start_run();
        tick(400);
        chk("bp_stall_en", ro_enable, 0);
        chk("bp_stall_done", meas_done, 0);
        chk("bp_stall_ten", bus.transfer_en, 1);
        chk("bp_stall_words", n_words - w0, 0);
        bus.transfer_active = 1'b1;
        wait_done(3000, "bp_done");
        chk("bp_words", n_words - w0, 12);

        // Abort during MEASURE of channel 2; two words stay drainable.
        bus.transfer_active = 1'b0;
        for (int k = 0; k < NR; k++) per[k] = 10;
        setup(0, 100, 1, 5, 3);
        push_exp(10, 1); push_exp(10, 1);
        w0 = n_words;
        start_run();
        wait_en(4'b0100, 1000, "ab_ch2");
        tick(20);
        meas_cmd[1] = 1'b1;
        tick(1);
        chk("ab_en", ro_enable, 0);
        meas_cmd[1] = 1'b0;
        tick(2);
        chk("ab_done", meas_done, 0);
        chk("ab_ten", bus.transfer_en, 1);
        bus.transfer_active = 1'b1;
        tick(20);
        chk("ab_words", n_words - w0, 2);
        chk("ab_done_after", meas_done, 0);
        chk("ab_empty", bus.transfer_en, 0);

        // Decouple with three words buffered; start attempted while decoupled.
        bus.transfer_active = 1'b0;
        setup(0, 100, 1, 5, 3);
        w0 = n_words; sw0 = n_swords;
        start_run();
        wait_en(4'b1000, 1000, "dc_ch3");
        chk("dc_pre_ten", bus.transfer_en, 1);
        DECOUPLE = 1'b1;
        tick(1);
        chk("dc_ten", bus.transfer_en, 0);
        chk("dc_en", ro_enable, 0);
        bus.transfer_active = 1'b1;
        meas_cmd[0] = 1'b1;
        tick(1);
        chk("dc_den", bus.data_en, 0);
        chk("dc_start_ign", ro_enable, 0);
        meas_cmd[0] = 1'b0;
        DECOUPLE = 1'b0;
        tick(20);
        chk("dc_empty", bus.transfer_en, 0);
        chk("dc_words", n_words - w0, 0);
        chk("dc_sat_words", n_swords - sw0, 0);
        chk("dc_idle_en", ro_enable, 0);
        chk("dc_done", meas_done, 0);

        // Saturation: 4-bit instance clips, 32-bit instance counts through.
        per[0] = 2; per[1] = 4; per[2] = 8; per[3] = 10;
        setup(1, 100, 1, 5, 3);
        push_exp(50, 1); push_exp(25, 1); push_exp(12, 1); push_exp(10, 1);
        w0 = n_words; sw0 = n_swords;
        start_run();
        wait_done(2000, "sat_done");
        chk("sat_main_words", n_words - w0, 4);
        chk("sat_words", n_swords - sw0, 4);
        chk("sat_inst_done", sat_meas_done, 1);

        chk("sb_left", exp_q.size(), 0);
        chk("sat_sb_left", sexp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ro_meas_seq_ctrl.md
Name: ro_meas_seq_ctrl

Overview:
Parametrised successor to the ring-oscillator measurement core. It sequences heat-up, gated counting, read-out and cool-down across NUM_RO ring oscillators. Two modes are supported: sequential (one RO at a time) and parallel (all ROs at once). Results go into an internal FIFO, which is drained to the PS-side DMA through the data_en/transfer_en/transfer_active handshake. The block sits between the RO array and the system block design; all meas_* control words come from PS registers.

Parameters:
NUM_RO, 8, number of RO channels (1..64)
CNT_WIDTH, 32, edge-counter width (1..32); results zero-extended to 32 bits
FIFO_DEPTH, 16, result FIFO depth in words (power of two, >=2)

Ports:
CLK  in  1  system clock (sys_clk0)
RESET  in  1  synchronous, active-high reset
DECOUPLE  in  1  partial-reconfiguration decouple; acts as abort plus FIFO flush while high
meas_cmd  in  32  bit0 start (rising edge), bit1 abort (level); other bits ignored
meas_mode  in  32  bit0: 0 sequential, 1 parallel; other bits ignored
meas_time  in  32  counting window in CLK cycles (0 treated as 1)
meas_readouts  in  32  number of full sweeps (0 treated as 1)
meas_heatup  in  32  cycles the RO(s) run before counting (0 = skip)
meas_cooldown  in  32  cycles all ROs are off after each window (0 = skip)
ro_in  in  NUM_RO  raw RO taps, asynchronous to CLK
ro_enable  out  NUM_RO  RO enables
data_out  out  32  result word
data_en  out  1  data_out valid; one word transferred per high cycle
transfer_en  out  1  transfer request to the DMA
transfer_active  in  1  DMA accepting words
meas_done  out  1  run complete and FIFO drained

Behaviour:
- Reset (RESET=1 at a CLK edge): FSM to IDLE; FIFO empty; counters cleared. ro_enable=0, data_out=0, data_en=0, transfer_en=0, meas_done=0.
- Control words are latched at start and held for the run. Register writes during a run have no effect.
- Edge counting:
  - Each ro_in bit passes through a 2-FF synchroniser, then a rising-edge detector.
  - A counter increments on a detected edge only in MEASURE, only for enabled channel(s).
  - Counters saturate at 2^CNT_WIDTH-1.
  - Edges still in the synchroniser pipeline when MEASURE ends are discarded.
  - Valid for RO tap frequency < CLK/2.
- FSM states: IDLE, HEAT, MEASURE, WRITE, COOL, DRAIN, DONE.
- IDLE/DONE:
  - A rising edge of meas_cmd[0] with abort=0 and DECOUPLE=0 clears meas_done, the channel index, the sweep counter and the counters.
  - Then go to HEAT, or to MEASURE if heatup=0.
- HEAT: ro_enable set (sequential: bit ch only; parallel: all ones) for meas_heatup cycles, then MEASURE.
- MEASURE:
  - ro_enable unchanged; lasts exactly meas_time cycles.
  - Then WRITE; ro_enable drops on entry to WRITE.
- WRITE:
  - Pushes one word per cycle when the FIFO is not full.
  - Sequential: 1 word (counter ch). Parallel: NUM_RO words, ch 0..NUM_RO-1 in order.
  - FIFO full → FSM stalls in WRITE; no word lost or reordered.
  - Afterwards go to COOL, or skip COOL if cooldown=0.
- COOL: ro_enable=0 for meas_cooldown cycles. Then pick the next state:
  - Sequential with ch<NUM_RO-1: ch+1, back to HEAT/MEASURE.
  - Otherwise, if sweeps remain: ch=0, next sweep.
  - Otherwise: DRAIN.
- DRAIN: wait for FIFO empty, then DONE with meas_done=1, held until the next start or reset.
- Total words per run: NUM_RO*readouts, in both modes.
- Transfer handshake:
  - transfer_en = FIFO not empty.
  - data_en = transfer_en & transfer_active, registered with 1-cycle latency: data_out/data_en are valid the cycle after the pop.
  - data_out holds its last value when data_en=0.
  - A simultaneous push and pop are both performed; the occupancy count is unchanged.
- Abort (meas_cmd[1]=1) in any state other than IDLE/DONE:
  - Next cycle: FSM to IDLE, ro_enable=0, counters cleared. meas_done stays 0.
  - FIFO contents are kept and remain drainable.
- DECOUPLE=1: same as abort, plus FIFO flushed, transfer_en=0 and data_en=0 while high. A start is ignored while DECOUPLE=1.
- RESET has priority over DECOUPLE, which has priority over abort, which has priority over start.

Test Plan:
- Reset: assert RESET 3 cycles mid-MEASURE → next cycle all outputs 0, FIFO empty; a subsequent start gives a fresh run.
- Sequential, NUM_RO=4:
  - Stimulus: ro_in[k] period 10 CLK; time=100, heatup=5, cooldown=3, readouts=1; transfer_active=1.
  - Response: 4 words, each 10±1, order ch0..3; only one ro_enable bit high at a time; meas_done=1 after the 4th data_en.
- Parallel, NUM_RO=4:
  - Stimulus: ro_in[k] period 2*(k+2); time=120; readouts=2.
  - Response: 8 words {30,20,15,12}x2 (±1); all ro_enable bits high together during HEAT/MEASURE.
- Backpressure:
  - Stimulus: FIFO_DEPTH=4, parallel, NUM_RO=4, readouts=3; transfer_active=0 until the FSM stalls in WRITE, then 1.
  - Response: 12 words in order, none lost; meas_done only after the last pop.
- Abort / DECOUPLE:
  - Abort during MEASURE of ch2 (sequential) → ro_enable=0 next cycle, exactly 2 words drainable, meas_done=0.
  - DECOUPLE pulse with 3 words in the FIFO → FIFO empty, no data_en.
- Saturation: CNT_WIDTH=4, ro_in period 2, time=100 → word = 15.
